// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm
// -------------
// Multi-cycle control sequencer for the 16-bit, 8-register processor
// datapath with RAM. Instructions are 9 bits, format III XXX YYY.
// Instructions are fetched from RAM at the address held in R7, which acts
// as the PC. The block then drives the datapath control strobes for each
// step of the instruction.
//
// Parameters:
//   RAM_LAT  RAM read latency in cycles, from the addr_in cycle until din
//            is valid. Legal values are 1..3.
//
// Ports:
//   clk      system clock; all state updates on the rising edge
//   rst      asynchronous, active-low reset
//   run      1 = execute instructions, 0 = stop after the current one
//   din      RAM read data (instruction or operand)
//   g_zero   1 when the ALU result register G is zero
//   ir       registered instruction register
//   r_in     one-hot register write enables R0..R7
//   r_out    one-hot register bus drive R0..R7
//   g_out    drive G onto the bus
//   din_out  drive RAM read data onto the bus
//   a_in     load ALU operand register A
//   g_in     load G from the ALU
//   add_sub  0 = add, 1 = subtract
//   addr_in  load the RAM address register from the bus
//   dout_in  load the RAM write-data register from the bus
//   incr_pc  increment R7
//   w        RAM write enable
//   done     high for one cycle, on the last step of each instruction
//   halted   (only with PROC_CTRL_HALT_EN) high while in HALT
//
// Optional feature:
//   Define PROC_CTRL_HALT_EN to turn opcode 111 into a halt. Only rst
//   leaves the HALT state. When the macro is undefined, 111 is a nop.
//
// Outputs are decoded combinationally from state, ir and g_zero only.
// As a result, they fall to zero as soon as rst is asserted.

module proc_ctrl_fsm #(
    parameter int RAM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [8:0] din,
    input  logic       g_zero,
    output logic [8:0] ir,
    output logic [7:0] r_in,
    output logic [7:0] r_out,
    output logic       g_out,
    output logic       din_out,
    output logic       a_in,
    output logic       g_in,
    output logic       add_sub,
    output logic       addr_in,
    output logic       dout_in,
    output logic       incr_pc,
    output logic       w,
    output logic       done
`ifdef PROC_CTRL_HALT_EN
    ,
    output logic       halted
`endif
);

    localparam int CW = $clog2(RAM_LAT + 1);
    // The reload value is the number of cycles still to wait after the
    // first one.
    localparam logic [CW-1:0] LAT_M1 = CW'(RAM_LAT - 1);

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        F1,
        FW,
        F3,
        T1,
        T2,
        T3
`ifdef PROC_CTRL_HALT_EN
        ,
        HALT
`endif
    } state_t;

    state_t          state;
    state_t          after_done;
    logic [CW-1:0]   wait_cnt;
    logic [2:0]      op;
    logic [7:0]      x_oh;
    logic [7:0]      y_oh;
    logic            single_step;

    assign op   = ir[8:6];
    assign x_oh = 8'b1 << ir[5:3];
    assign y_oh = 8'b1 << ir[2:0];

    // mv, mvnz and nop finish in T1. Every other opcode runs T1..T3.
    assign single_step = (op == OP_MV) || (op == OP_MVNZ) || (op == OP_NOP);

    // run is sampled only here and in IDLE. A drop in run mid-instruction
    // therefore takes effect at the next instruction boundary.
    always_comb begin
        after_done = run ? F1 : IDLE;
`ifdef PROC_CTRL_HALT_EN
        if (op == OP_NOP)
            after_done = HALT;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (run) state <= F1;
                F1: begin
                    state    <= FW;
                    wait_cnt <= LAT_M1;
                end
                FW: begin
                    if (wait_cnt == '0) state <= F3;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                F3: begin
                    ir    <= din;
                    state <= T1;
                end
                T1: begin
                    if (single_step) begin
                        state <= after_done;
                    end else begin
                        state    <= T2;
                        // Only the RAM-reading opcodes wait in T2. The
                        // others spend exactly one cycle there.
                        wait_cnt <= (op == OP_MVI || op == OP_LD) ? LAT_M1 : '0;
                    end
                end
                T2: begin
                    if (wait_cnt == '0) state <= T3;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                T3: state <= after_done;
`ifdef PROC_CTRL_HALT_EN
                HALT: state <= HALT;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        r_in    = '0;
        r_out   = '0;
        g_out   = 1'b0;
        din_out = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        add_sub = 1'b0;
        addr_in = 1'b0;
        dout_in = 1'b0;
        incr_pc = 1'b0;
        w       = 1'b0;
        done    = 1'b0;
        case (state)
            F1: begin
                r_out   = 8'h80;
                addr_in = 1'b1;
            end
            // wait_cnt still holds its reload value in the first wait cycle.
            FW: incr_pc = (wait_cnt == LAT_M1);
            T1: begin
                case (op)
                    OP_MV: begin
                        r_out = y_oh;
                        r_in  = x_oh;
                        done  = 1'b1;
                    end
                    OP_MVI: begin
                        r_out   = 8'h80;
                        addr_in = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        r_out = x_oh;
                        a_in  = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        r_out   = y_oh;
                        addr_in = 1'b1;
                    end
                    OP_MVNZ: begin
                        if (!g_zero) begin
                            r_out = y_oh;
                            r_in  = x_oh;
                        end
                        done = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                case (op)
                    OP_MVI: incr_pc = (wait_cnt == LAT_M1);
                    OP_ADD, OP_SUB: begin
                        r_out   = y_oh;
                        g_in    = 1'b1;
                        add_sub = (op == OP_SUB);
                    end
                    OP_ST: begin
                        r_out   = x_oh;
                        dout_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            T3: begin
                case (op)
                    OP_MVI, OP_LD: begin
                        din_out = 1'b1;
                        r_in    = x_oh;
                    end
                    OP_ADD, OP_SUB: begin
                        g_out = 1'b1;
                        r_in  = x_oh;
                    end
                    OP_ST: w = 1'b1;
                    default: ;
                endcase
                done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PROC_CTRL_HALT_EN
    assign halted = (state == HALT);
`endif

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb_proc_ctrl_fsm
// ----------------
// Self-checking bench for proc_ctrl_fsm in the default build (no halt).
// A small behavioural datapath model (registers, A, G, address and
// write-data registers, RAM) follows the DUT's control strobes.
// The expected control vector for every cycle is queued when an
// instruction is scheduled, and each vector is popped on the falling edge.

module tb_proc_ctrl_fsm;

    localparam int RAM_LAT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [8:0] din;
    logic       g_zero;
    logic [8:0] ir;
    logic [7:0] r_in;
    logic [7:0] r_out;
    logic       g_out, din_out, a_in, g_in, add_sub, addr_in, dout_in, incr_pc, w, done;

    int checks;
    int failures;

    always #5 clk = ~clk;

    proc_ctrl_fsm #(.RAM_LAT(RAM_LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .din     (din),
        .g_zero  (g_zero),
        .ir      (ir),
        .r_in    (r_in),
        .r_out   (r_out),
        .g_out   (g_out),
        .din_out (din_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .add_sub (add_sub),
        .addr_in (addr_in),
        .dout_in (dout_in),
        .incr_pc (incr_pc),
        .w       (w),
        .done    (done)
    );

    // Datapath model. A program image is copied into RAM while load_now is set.
    logic [8:0]  prog [128];
    logic [8:0]  ram  [128];
    logic [15:0] regs [8];
    logic [15:0] a_reg, g_reg, addr_reg, dout_reg;
    logic [15:0] bus;
    logic        load_now;

    always_comb begin
        bus = '0;
        for (int i = 0; i < 8; i++)
            if (r_out[i]) bus = regs[i];
        if (g_out)   bus = g_reg;
        if (din_out) bus = {7'b0, din};
    end

    assign din    = ram[addr_reg[6:0]];
    assign g_zero = (g_reg == 16'd0);

    always @(posedge clk) begin
        if (load_now) begin
            for (int i = 0; i < 128; i++) ram[i] <= prog[i];
            for (int i = 0; i < 8; i++)   regs[i] <= '0;
            a_reg    <= '0;
            g_reg    <= '0;
            addr_reg <= '0;
            dout_reg <= '0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (r_in[i]) regs[i] <= bus;
            if (incr_pc) regs[7]  <= regs[7] + 16'd1;
            if (a_in)    a_reg    <= bus;
            if (g_in)    g_reg    <= add_sub ? a_reg - bus : a_reg + bus;
            if (addr_in) addr_reg <= bus;
            if (dout_in) dout_reg <= bus;
            if (w)       ram[addr_reg[6:0]] <= dout_reg[8:0];
        end
    end

    // Control vector layout: {r_in, r_out, g_out, din_out, a_in, g_in,
    // add_sub, addr_in, dout_in, incr_pc, w, done}
    localparam logic [25:0] DONE    = 26'd1 << 0;
    localparam logic [25:0] WR      = 26'd1 << 1;
    localparam logic [25:0] INCR    = 26'd1 << 2;
    localparam logic [25:0] DOUT_IN = 26'd1 << 3;
    localparam logic [25:0] ADDR_IN = 26'd1 << 4;
    localparam logic [25:0] ADD_SUB = 26'd1 << 5;
    localparam logic [25:0] G_IN    = 26'd1 << 6;
    localparam logic [25:0] A_IN    = 26'd1 << 7;
    localparam logic [25:0] DIN_OUT = 26'd1 << 8;
    localparam logic [25:0] G_OUT   = 26'd1 << 9;

    function automatic logic [25:0] rout_bit(input logic [2:0] i);
        return 26'd1 << (10 + int'(i));
    endfunction

    function automatic logic [25:0] rin_bit(input logic [2:0] i);
        return 26'd1 << (18 + int'(i));
    endfunction

    typedef struct {
        logic [25:0] ctrl;
        logic [8:0]  ir;
        bit          chk_ir;
        string       tag;
    } exp_t;

    exp_t sb[$];

    task automatic pushStep(input logic [25:0] c, input logic [8:0] instr,
                            input bit ci, input string t);
        exp_t e;
        e.ctrl   = c;
        e.ir     = instr;
        e.chk_ir = ci;
        e.tag    = t;
        sb.push_back(e);
    endtask

    task automatic pushIdle(input int n);
        for (int k = 0; k < n; k++) pushStep('0, '0, 1'b0, "idle");
    endtask

    // Expected per-cycle strobes for one complete instruction, including fetch.
    task automatic pushInstr(input logic [8:0] instr, input bit gz, input string name);
        logic [2:0] op, x, y;
        op = instr[8:6];
        x  = instr[5:3];
        y  = instr[2:0];
        pushStep(rout_bit(3'd7) | ADDR_IN, instr, 1'b0, {name, "_F1"});
        for (int k = 0; k < RAM_LAT; k++)
            pushStep((k == 0) ? INCR : 26'd0, instr, 1'b0, {name, "_FW"});
        pushStep('0, instr, 1'b0, {name, "_F3"});
        case (op)
            3'b000: pushStep(rout_bit(y) | rin_bit(x) | DONE, instr, 1'b1, {name, "_T1"});
            3'b001: begin
                pushStep(rout_bit(3'd7) | ADDR_IN, instr, 1'b1, {name, "_T1"});
                for (int k = 0; k < RAM_LAT; k++)
                    pushStep((k == 0) ? INCR : 26'd0, instr, 1'b1, {name, "_T2"});
                pushStep(DIN_OUT | rin_bit(x) | DONE, instr, 1'b1, {name, "_T3"});
            end
            3'b010, 3'b011: begin
                pushStep(rout_bit(x) | A_IN, instr, 1'b1, {name, "_T1"});
                pushStep(rout_bit(y) | G_IN | ((op == 3'b011) ? ADD_SUB : 26'd0),
                         instr, 1'b1, {name, "_T2"});
                pushStep(G_OUT | rin_bit(x) | DONE, instr, 1'b1, {name, "_T3"});
            end
            3'b100: begin
                pushStep(rout_bit(y) | ADDR_IN, instr, 1'b1, {name, "_T1"});
                for (int k = 0; k < RAM_LAT; k++)
                    pushStep('0, instr, 1'b1, {name, "_T2"});
                pushStep(DIN_OUT | rin_bit(x) | DONE, instr, 1'b1, {name, "_T3"});
            end
            3'b101: begin
                pushStep(rout_bit(y) | ADDR_IN, instr, 1'b1, {name, "_T1"});
                pushStep(rout_bit(x) | DOUT_IN, instr, 1'b1, {name, "_T2"});
                pushStep(WR | DONE, instr, 1'b1, {name, "_T3"});
            end
            3'b110: pushStep(gz ? DONE : (rout_bit(y) | rin_bit(x) | DONE),
                             instr, 1'b1, {name, "_T1"});
            default: pushStep(DONE, instr, 1'b1, {name, "_T1"});
        endcase
    endtask

    task automatic applyStimulus(input logic run_val);
        run = run_val;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [25:0] obs;
        obs = {r_in, r_out, g_out, din_out, a_in, g_in, add_sub, addr_in, dout_in,
               incr_pc, w, done};
        checks++;
        assert (obs === e.ctrl) else begin
            failures++;
            $error("[TB] FAIL %s ctrl: observed %h expected %h", e.tag, obs, e.ctrl);
        end
        checks++;
        assert ($countones({r_out, g_out, din_out}) <= 1) else begin
            failures++;
            $error("[TB] FAIL %s bus_excl: observed %b expected at most one driver",
                   e.tag, {r_out, g_out, din_out});
        end
        if (e.chk_ir) begin
            checks++;
            assert (ir === e.ir) else begin
                failures++;
                $error("[TB] FAIL %s ir: observed %h expected %h", e.tag, ir, e.ir);
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Pops count queued vectors, one per falling edge. run is dropped right
    // after the check at index drop_at.
    task automatic runChecked(input int count, input int drop_at);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("[TB] FAIL scoreboard: observed empty queue expected entry");
                return;
            end
            e = sb.pop_front();
            checkOutput(e);
            if (i == drop_at) applyStimulus(1'b0);
        end
    endtask

    task automatic drainAll(input int drop_last);
        int n;
        n = sb.size();
        runChecked(n, drop_last ? n - 1 : -1);
    endtask

    initial begin
        exp_t z;
        checks   = 0;
        failures = 0;
        run      = 1'b0;
        rst      = 1'b0;
        load_now = 1'b1;
        for (int i = 0; i < 128; i++) prog[i] = '0;
        prog[0]    = 9'b001_000_000; prog[1]  = 9'h005;  // mvi R0,#5
        prog[2]    = 9'b001_001_000; prog[3]  = 9'h003;  // mvi R1,#3
        prog[4]    = 9'b001_010_000; prog[5]  = 9'h004;  // mvi R2,#4
        prog[6]    = 9'b010_001_010;                     // add R1,R2
        prog[7]    = 9'b011_011_011;                     // sub R3,R3 -> G=0
        prog[8]    = 9'b110_011_100;                     // mvnz R3,R4 (G==0)
        prog[9]    = 9'b010_100_001;                     // add R4,R1 -> G=7
        prog[10]   = 9'b110_011_100;                     // mvnz R3,R4 (G!=0)
        prog[11]   = 9'b001_110_000; prog[12] = 9'h040;  // mvi R6,#0x40
        prog[13]   = 9'b000_101_000;                     // mv R5,R0
        prog[14]   = 9'b101_101_110;                     // st R5,R6
        prog[15]   = 9'b100_010_110;                     // ld R2,R6
        prog[16]   = 9'b111_000_000;                     // nop
        prog[17]   = 9'b001_111_000; prog[18] = 9'h020;  // mvi R7,#0x20 (jump)
        prog[32]   = 9'b010_001_000;                     // add R1,R0
        prog[33]   = 9'b000_000_001;                     // mv R0,R1
        prog[34]   = 9'b001_100_000; prog[35] = 9'h1AA;  // mvi R4,#0x1AA
        z.ctrl = '0; z.ir = '0; z.chk_ir = 1'b1; z.tag = "reset";

        repeat (2) @(posedge clk);
        @(negedge clk);
        load_now = 1'b0;
        checkOutput(z);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        z.tag = "idle_run0";
        checkOutput(z);

        $display("[TB] main program");
        pushInstr(prog[0],  1'b0, "mvi_r0");
        pushInstr(prog[2],  1'b0, "mvi_r1");
        pushInstr(prog[4],  1'b0, "mvi_r2");
        pushInstr(prog[6],  1'b0, "add_r1r2");
        pushInstr(prog[7],  1'b0, "sub_r3r3");
        pushInstr(prog[8],  1'b1, "mvnz_gz1");
        pushInstr(prog[9],  1'b0, "add_r4r1");
        pushInstr(prog[10], 1'b0, "mvnz_gz0");
        pushInstr(prog[11], 1'b0, "mvi_r6");
        pushInstr(prog[13], 1'b0, "mv_r5r0");
        pushInstr(prog[14], 1'b0, "st_r5r6");
        pushInstr(prog[15], 1'b0, "ld_r2r6");
        pushInstr(prog[16], 1'b0, "nop");
        pushInstr(prog[17], 1'b0, "mvi_r7");
        applyStimulus(1'b1);
        drainAll(1);
        pushIdle(3);
        drainAll(0);
        checkValue("r0_after_mvi", regs[0], 16'd5);
        checkValue("r1_after_add", regs[1], 16'd7);
        checkValue("r3_after_mvnz", regs[3], 16'd7);
        checkValue("r4_after_add", regs[4], 16'd7);
        checkValue("r2_after_ld", regs[2], 16'd5);
        checkValue("ram_after_st", {7'b0, ram[64]}, 16'd5);
        checkValue("pc_after_jump", regs[7], 16'h20);

        $display("[TB] run dropped mid-instruction");
        pushInstr(prog[32], 1'b0, "add_r1r0");
        pushIdle(4);
        applyStimulus(1'b1);
        runChecked(sb.size(), RAM_LAT + 3);
        pushInstr(prog[33], 1'b0, "mv_r0r1");
        applyStimulus(1'b1);
        drainAll(1);
        pushIdle(2);
        drainAll(0);
        checkValue("r1_after_add2", regs[1], 16'd12);
        checkValue("r0_after_mv", regs[0], 16'd12);
        checkValue("pc_before_abort", regs[7], 16'h22);

        $display("[TB] reset during mvi T2");
        pushInstr(prog[34], 1'b0, "mvi_r4");
        applyStimulus(1'b1);
        runChecked(RAM_LAT + 4, -1);
        sb.delete();
        #2 rst = 1'b0;
        #1;
        z.tag = "async_reset";
        z.chk_ir = 1'b1;
        checkOutput(z);
        applyStimulus(1'b0);
        repeat (2) begin
            @(negedge clk);
            z.tag = "held_reset";
            checkOutput(z);
        end
        rst = 1'b1;
        @(negedge clk);
        z.tag = "idle_after_reset";
        checkOutput(z);
        checkValue("r4_not_written", regs[4], 16'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proc_ctrl_fsm.md
Name: proc_ctrl_fsm

Overview:
Multi-cycle control sequencer for the 16-bit, 8-register processor datapath with RAM.
- Fetches a 9-bit instruction (format III XXX YYY) from RAM, addressed by R7 acting as the PC.
- Decodes it and drives the bus-mux selects, register enables, ALU control and the RAM write strobe for each instruction step.
- Sits between the RAM read port and the datapath; the top-level `run` input gates execution.

Parameters:
- RAM_LAT, 1, RAM read latency in cycles between the `addr_in` cycle and valid `din`; legal values 1..3.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- run  input  1  level; 1 = execute instructions, 0 = stop after current instruction
- din  input  9  RAM read data (instruction or operand)
- g_zero  input  1  1 when ALU result register G == 0
- ir  output  9  registered instruction register
- r_in  output  8  one-hot register write enables R0..R7
- r_out  output  8  one-hot register bus drive R0..R7
- g_out  output  1  drive G onto bus
- din_out  output  1  drive RAM data onto bus
- a_in  output  1  load ALU operand register A
- g_in  output  1  load G from ALU
- add_sub  output  1  0 = add, 1 = subtract
- addr_in  output  1  load RAM address register from bus
- dout_in  output  1  load RAM write-data register from bus
- incr_pc  output  1  increment R7
- w  output  1  RAM write enable
- done  output  1  pulses 1 cycle on the last step of each instruction

Behaviour:
- Reset (rst=0, async): state=IDLE, ir=0, wait counter=0. All other outputs are 0 while in reset and in IDLE.
- Outputs are decoded combinationally from registered state, registered ir and g_zero only. They never depend directly on din or run.
- At most one bit of r_out, g_out or din_out is asserted in any cycle (bus exclusivity); the verifier checks this every cycle.
- IDLE: if run=1 go to F1, else stay.
- F1: r_out[7]=1, addr_in=1, then go to FW.
- FW: incr_pc=1 in the first FW cycle only. Stay RAM_LAT cycles in total, then go to F3.
- F3: load ir<=din, then go to T1.
- Per-opcode steps (III):
  - 000 mv: T1 r_out[Y], r_in[X], done.
  - 001 mvi: T1 r_out[7], addr_in. T2 for RAM_LAT cycles, incr_pc in the first only. T3 din_out, r_in[X], done.
  - 010 add: T1 r_out[X], a_in. T2 r_out[Y], g_in, add_sub=0. T3 g_out, r_in[X], done.
  - 011 sub: same as add, with add_sub=1 in T2.
  - 100 ld: T1 r_out[Y], addr_in. T2 wait RAM_LAT cycles. T3 din_out, r_in[X], done.
  - 101 st: T1 r_out[Y], addr_in. T2 r_out[X], dout_in. T3 w=1, done.
  - 110 mvnz: T1: if g_zero=0, r_out[Y] and r_in[X]; else no enables. done=1 in both cases.
  - 111 nop: T1 done only.
- After any done cycle: go to F1 if run=1, else IDLE. run is sampled only in done cycles and in IDLE; deasserting run mid-instruction completes that instruction.
- X=7 destinations write the PC; this is a legal jump and the next fetch uses the new R7.
- Reset asserted mid-instruction aborts immediately: no further r_in or w pulses, and the FSM restarts in IDLE.
- Wait counter width is ceil(log2(RAM_LAT+1)); it reloads on entry to FW and T2.

Optional Feature:
- Macro PROC_CTRL_HALT_EN.
- Defined:
  - Opcode 111 enters HALT after its done cycle. In HALT all outputs are 0 and run is ignored.
  - Only rst leaves HALT.
  - Extra output `halted` (1 bit) = 1 in HALT, 0 in reset.
- Undefined: 111 is nop as above, and there is no HALT state and no `halted` port.

Test Plan:
- Reset then run=1, RAM_LAT=1, RAM[0]=001_000_000, RAM[1]=0x005 -> 3 fetch + 3 execute cycles; r_in[0] with din_out in the done cycle; incr_pc pulsed twice.
- add R1,R2 (010_001_010), R1=3, R2=4 -> T1 a_in with r_out[1]; T2 g_in, add_sub=0, r_out[2]; T3 g_out, r_in[1], done; R1=7.
- mvnz R3,R4 with g_zero=1, then with g_zero=0 -> first instance has no r_in and done=1; second has r_out[4] and r_in[3].
- st R5,R6 (101_101_110) -> T1 addr_in with r_out[6]; T2 dout_in with r_out[5]; T3 w=1 exactly one cycle.
- run dropped during add's T2 -> instruction completes with done, then IDLE; no addr_in until run returns to 1.
- rst pulsed low during mvi T2 -> all outputs 0 asynchronously, ir=0, no r_in; with HALT_EN, opcode 111 -> halted=1 and the FSM stays in HALT for 20 cycles with run=1.
